// File: rtl/acs_pmu4.sv
// Add-compare-select and path-metric unit for a K=3, rate-1/2 (7,5) Viterbi decoder.
// One trellis step per accepted cycle, normalised metrics registered with 1-cycle latency.
module acs_pmu4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] bm_00,
  input  logic [1:0] bm_01,
  input  logic [1:0] bm_10,
  input  logic [1:0] bm_11,
  output logic       out_valid,
  output logic [3:0] dec,
  output logic [5:0] pm0,
  output logic [5:0] pm1,
  output logic [5:0] pm2,
  output logic [5:0] pm3,
  output logic [1:0] best_state
);

  localparam int DATA_W = 6;
  localparam logic [DATA_W-1:0] PM_INIT_HI = 6'd16;
  localparam logic [DATA_W:0]   PM_MAX     = 7'd63;

  logic [DATA_W-1:0] pm_q   [4];
  logic [DATA_W-1:0] pm_d   [4];
  logic [3:0]        dec_q, dec_d;
  logic [1:0]        best_q, best_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] prev  [4];
  logic [DATA_W:0]   cand0 [4];
  logic [DATA_W:0]   cand1 [4];
  logic [DATA_W:0]   newm  [4];
  logic [DATA_W-1:0] norm  [4];
  logic [3:0]        sel;
  logic [DATA_W:0]   min_new;
  logic [DATA_W-1:0] best_val;
  logic [1:0]        best_idx;

  function automatic logic [DATA_W-1:0] sat_pm(input logic [DATA_W:0] v);
    return (v > PM_MAX) ? PM_MAX[DATA_W-1:0] : v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W:0] ext_bm(input logic [1:0] b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

  // ACS: predecessors of state {u,n0} are {n0,0} (cand0) and {n0,1} (cand1)
  always_comb begin
    prev[0] = start ? '0         : pm_q[0];
    prev[1] = start ? PM_INIT_HI : pm_q[1];
    prev[2] = start ? PM_INIT_HI : pm_q[2];
    prev[3] = start ? PM_INIT_HI : pm_q[3];

    cand0[0] = {1'b0, prev[0]} + ext_bm(bm_00);
    cand1[0] = {1'b0, prev[1]} + ext_bm(bm_11);
    cand0[1] = {1'b0, prev[2]} + ext_bm(bm_10);
    cand1[1] = {1'b0, prev[3]} + ext_bm(bm_01);
    cand0[2] = {1'b0, prev[0]} + ext_bm(bm_11);
    cand1[2] = {1'b0, prev[1]} + ext_bm(bm_00);
    cand0[3] = {1'b0, prev[2]} + ext_bm(bm_01);
    cand1[3] = {1'b0, prev[3]} + ext_bm(bm_10);

    for (int n = 0; n < 4; n++) begin
      sel[n]  = cand1[n] < cand0[n];
      newm[n] = sel[n] ? cand1[n] : cand0[n];
    end

    min_new = newm[0];
    for (int n = 1; n < 4; n++)
      if (newm[n] < min_new) min_new = newm[n];

    for (int n = 0; n < 4; n++)
      norm[n] = sat_pm(newm[n] - min_new);

    // strict less-than keeps the lowest index on ties
    best_idx = 2'd0;
    best_val = norm[0];
    for (int n = 1; n < 4; n++) begin
      if (norm[n] < best_val) begin
        best_val = norm[n];
        best_idx = 2'(n);
      end
    end
  end

  always_comb begin
    pm_d        = pm_q;
    dec_d       = dec_q;
    best_d      = best_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      pm_d        = norm;
      dec_d       = sel;
      best_d      = best_idx;
      out_valid_d = 1'b1;
    end else if (start) begin
      pm_d[0] = '0;
      pm_d[1] = PM_INIT_HI;
      pm_d[2] = PM_INIT_HI;
      pm_d[3] = PM_INIT_HI;
      dec_d   = '0;
      best_d  = '0;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q[0]     <= '0;
      pm_q[1]     <= PM_INIT_HI;
      pm_q[2]     <= PM_INIT_HI;
      pm_q[3]     <= PM_INIT_HI;
      dec_q       <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      dec_q       <= dec_d;
      best_q      <= best_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign dec        = dec_q;
  assign best_state = best_q;
  assign pm0        = pm_q[0];
  assign pm1        = pm_q[1];
  assign pm2        = pm_q[2];
  assign pm3        = pm_q[3];

endmodule
